// File: rtl/wordle_pkg.sv
// Shared definitions for the wordle game: colour codes, word geometry, scorer state encoding.
// Pure definitions, no timing and no flow control.
package wordle_pkg;

    localparam int LETTERS = 5;
    localparam int CHAR_W  = 8;
    localparam int WORD_W  = LETTERS * CHAR_W;

    localparam logic [1:0] COL_GRAY   = 2'b00;
    localparam logic [1:0] COL_YELLOW = 2'b01;
    localparam logic [1:0] COL_GREEN  = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_GREEN  = 4'b0010,
        ST_YELLOW = 4'b0100,
        ST_DONE   = 4'b1000
    } scorer_state_t;

    // Letter 0 sits in the most significant character of the packed word.
    function automatic logic [CHAR_W-1:0] letter_of(input logic [WORD_W-1:0] word,
                                                    input logic [2:0] idx);
        return word[(LETTERS - 1 - int'(idx)) * CHAR_W +: CHAR_W];
    endfunction

endpackage

// File: rtl/wordle_letter_match.sv
// Finds the lowest unused target position holding a given guess letter.
// Combinational, zero latency; no flow control.
module wordle_letter_match #(
    parameter int LETTERS = 5,
    parameter int CHAR_W  = 8
) (
    input  logic [CHAR_W-1:0]         guess_letter,
    input  logic [LETTERS*CHAR_W-1:0] target_word,
    input  logic [LETTERS-1:0]        used,
    output logic                      hit,
    output logic [LETTERS-1:0]        claim
);

    always_comb begin
        hit   = 1'b0;
        claim = '0;
        for (int j = 0; j < LETTERS; j++) begin
            if (!hit && !used[j] &&
                target_word[(LETTERS - 1 - j) * CHAR_W +: CHAR_W] == guess_letter) begin
                hit      = 1'b1;
                claim[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wordle_scorer.sv
// Two-pass duplicate-aware wordle scorer: one letter per cycle, green pass then yellow pass.
// Latency fixed at 10 edges from accept to done; start is ignored (not queued) while busy.
module wordle_scorer #(
    parameter int LETTERS = 5,
    parameter int CHAR_W  = 8
) (
    input  logic                      Clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [LETTERS*CHAR_W-1:0] guessWord,
    input  logic [LETTERS*CHAR_W-1:0] randomWord,
    output logic                      busy,
    output logic                      done,
    output logic [2*LETTERS-1:0]      result,
    output logic                      all_green
);
    import wordle_pkg::*;

    localparam logic [2:0]           LAST_IDX  = 3'(LETTERS - 1);
    localparam logic [2*LETTERS-1:0] ALL_GREEN = {LETTERS{COL_GREEN}};

    scorer_state_t               state;
    logic [LETTERS*CHAR_W-1:0]   guess_q;
    logic [LETTERS*CHAR_W-1:0]   target_q;
    logic [LETTERS-1:0]          used;
    logic [2:0]                  i;

    int                          pos;
    logic [CHAR_W-1:0]           g_ch;
    logic [CHAR_W-1:0]           t_ch;
    logic                        hit;
    logic [LETTERS-1:0]          claim;
    logic                        take_yellow;
    logic [2*LETTERS-1:0]        result_nxt;

    always_comb begin
        pos         = LETTERS - 1 - int'(i);
        g_ch        = guess_q[pos * CHAR_W +: CHAR_W];
        t_ch        = target_q[pos * CHAR_W +: CHAR_W];
        take_yellow = (result[pos * 2 +: 2] != COL_GREEN) && hit;
        result_nxt  = result;
        if (take_yellow) begin
            result_nxt[pos * 2 +: 2] = COL_YELLOW;
        end
    end

    wordle_letter_match #(
        .LETTERS (LETTERS),
        .CHAR_W  (CHAR_W)
    ) u_match (
        .guess_letter (g_ch),
        .target_word  (target_q),
        .used         (used),
        .hit          (hit),
        .claim        (claim)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            guess_q   <= '0;
            target_q  <= '0;
            used      <= '0;
            i         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            all_green <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        guess_q   <= guessWord;
                        target_q  <= randomWord;
                        used      <= '0;
                        result    <= '0;
                        all_green <= 1'b0;
                        i         <= '0;
                        busy      <= 1'b1;
                        state     <= ST_GREEN;
                    end
                end
                ST_GREEN: begin
                    if (g_ch == t_ch) begin
                        result[pos * 2 +: 2] <= COL_GREEN;
                        used[i]              <= 1'b1;
                    end
                    if (i == LAST_IDX) begin
                        i     <= '0;
                        state <= ST_YELLOW;
                    end else begin
                        i <= i + 3'd1;
                    end
                end
                ST_YELLOW: begin
                    // Greens already own their target slots, so claims only come from unused ones.
                    if (take_yellow) begin
                        result <= result_nxt;
                        used   <= used | claim;
                    end
                    if (i == LAST_IDX) begin
                        i         <= '0;
                        done      <= 1'b1;
                        all_green <= (result_nxt == ALL_GREEN);
                        state     <= ST_DONE;
                    end else begin
                        i <= i + 3'd1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
